// File: rtl/wtm_32.sv
// Unsigned 32x32 Wallace-tree multiplier: carry-save tree -> reg -> 64-bit CPA -> reg.
// Latency 2 cycles, one operand pair accepted per cycle.
// No backpressure: operands are sampled on every edge and s updates every cycle.

// One Wallace level: rows are taken three at a time through 3:2 compressors and
// leftover rows pass straight through.
module wtm_csa_level #(
    parameter int N = 32,
    parameter int M = 2 * (N / 3) + (N % 3)
) (
    input  logic [63:0] din  [N],
    output logic [63:0] dout [M]
);
    localparam int G = N / 3;

    for (genvar k = 0; k < G; k++) begin : g_csa
        assign dout[2*k]   = din[3*k] ^ din[3*k+1] ^ din[3*k+2];
        // Carry weight moves up one column; anything out of bit 63 cannot matter
        // because the final product always fits in 64 bits.
        assign dout[2*k+1] = ((din[3*k]   & din[3*k+1]) |
                              (din[3*k]   & din[3*k+2]) |
                              (din[3*k+1] & din[3*k+2])) << 1;
    end

    for (genvar r = 3 * G; r < N; r++) begin : g_pass
        assign dout[2*G + (r - 3*G)] = din[r];
    end
endmodule

// Top: partial products, eight tree levels (32,22,15,10,7,5,4,3,2), then two
// pipeline registers separating the tree from the final adder.
module wtm_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] s,
    input  logic        clk,
    input  logic        rst
);
    logic [63:0] pp [32];
    logic [63:0] l1 [22];
    logic [63:0] l2 [15];
    logic [63:0] l3 [10];
    logic [63:0] l4 [7];
    logic [63:0] l5 [5];
    logic [63:0] l6 [4];
    logic [63:0] l7 [3];
    logic [63:0] l8 [2];

    logic [63:0] sum_q;
    logic [63:0] carry_q;

    for (genvar i = 0; i < 32; i++) begin : g_pp
        assign pp[i] = {32'b0, x & {32{y[i]}}} << i;
    end

    wtm_csa_level #(.N(32)) u_l1 (.din(pp), .dout(l1));
    wtm_csa_level #(.N(22)) u_l2 (.din(l1), .dout(l2));
    wtm_csa_level #(.N(15)) u_l3 (.din(l2), .dout(l3));
    wtm_csa_level #(.N(10)) u_l4 (.din(l3), .dout(l4));
    wtm_csa_level #(.N(7))  u_l5 (.din(l4), .dout(l5));
    wtm_csa_level #(.N(5))  u_l6 (.din(l5), .dout(l6));
    wtm_csa_level #(.N(4))  u_l7 (.din(l6), .dout(l7));
    wtm_csa_level #(.N(3))  u_l8 (.din(l7), .dout(l8));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            s       <= '0;
        end else begin
            sum_q   <= l8[0];
            carry_q <= l8[1];
            s       <= sum_q + carry_q;
        end
    end
endmodule

// File: tb/tb_wtm_32.sv
// Scoreboard bench for wtm_32: the driver queues expected products, a monitor pops
// and compares them exactly two edges after each operand pair is applied.
module tb_wtm_32;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] s;

    logic [63:0] exp_q [$];
    logic        drv_vld;
    logic        tag_p1;
    logic        tag_p2;
    int          n_checks = 0;
    int          n_fail   = 0;

    wtm_32 dut (
        .x  (x),
        .y  (y),
        .s  (s),
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: s=0x%h required 0x%h", name, got, req);
        end
    endtask

    // Applies a pair at the falling edge and queues its expected product.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        @(negedge clk);
        x = a;
        y = b;
        drv_vld = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drv_vld = 1'b0;
        end
    endtask

    // Tracks which output cycles carry a queued product; a reset discards in-flight ones.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_p1 <= 1'b0;
            tag_p2 <= 1'b0;
        end else begin
            tag_p1 <= drv_vld;
            tag_p2 <= tag_p1;
        end
    end

    always @(negedge clk) begin
        if (tag_p2) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: s=0x%h with no expected entry", s);
            end else begin
                check("scoreboard", s, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        x = '0;
        y = '0;
        drv_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", s, 64'd0);

        @(negedge clk);
        rst = 1'b0;

        // Repunit squares, back to back.
        issue(32'd11,      32'd11,      64'd121);
        issue(32'd111,     32'd111,     64'd12321);
        issue(32'd1111,    32'd1111,    64'd1234321);
        issue(32'd11111,   32'd11111,   64'd123454321);
        issue(32'd111111,  32'd111111,  64'd12345654321);
        issue(32'd1111111, 32'd1111111, 64'd1234567654321);

        // Boundaries.
        issue(32'd0,          32'hFFFFFFFF, 64'd0);
        issue(32'd1,          32'hDEADBEEF, 64'h00000000DEADBEEF);
        issue(32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        issue(32'h80000000,   32'd2,        64'h0000000100000000);

        // Latency: consecutive pairs must come out on consecutive edges.
        issue(32'd7,   32'd9,   64'd63);
        issue(32'd100, 32'd100, 64'd10000);
        idle(3);

        // Reset while nonzero products are in flight.
        issue(32'd1000,  32'd1000, 64'd1000000);
        issue(32'd12345, 32'd6789, 64'd83810205);
        issue(32'd65535, 32'd65537, 64'd4294967295);
        @(posedge clk);
        #1 check("pre_reset", s, 64'd83810205);
        #1;
        rst = 1'b1;
        drv_vld = 1'b0;
        exp_q.delete();
        #1 check("async_clear", s, 64'd0);
        x = 32'hFFFF;
        y = 32'hFFFF;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", s, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        x = 32'd3;
        y = 32'd5;
        drv_vld = 1'b1;
        exp_q.push_back(64'd15);
        @(posedge clk);
        #1 check("release_edge1", s, 64'd0);
        issue(32'd3, 32'd5, 64'd15);
        idle(3);

        // Random regression.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i < 4) begin
                a = (i % 2 == 0) ? 32'hFFFFFFFF : a;
                b = (i < 2) ? 32'hFFFFFFFF : b;
            end
            issue(a, b, {32'b0, a} * {32'b0, b});
        end
        idle(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
